// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the multi-port register file.
// Provides default geometry constants, the hardwired-zero address, and
// a helper for locating a port's field inside a packed multi-port bus.
package rf_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_ADDR      = 0;

    // Low bit index of port `port` in a packed bus of `width`-bit fields.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write tracking for the register file.
// Holds one pending bit per register, sets it on accepted issue, clears it
// on writeback, raises stall on a write-after-write hazard, and reports
// per-read-port busy status.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rd_addr      : packed read addresses (NUM_RD x ADDR_W)
//   wr_en/wr_addr: writeback strobe/address (clears pending)
//   iss_en/addr  : issue strobe/destination (sets pending)
//   rd_busy      : per-port outstanding-write flag
//   stall        : issue refused this cycle
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     stall
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

    logic [DEPTH-1:0] pending_q;
    logic [DEPTH-1:0] pending_d;
    logic             wr_zero;
    logic             iss_zero;

    always_comb begin
        wr_zero  = (ZERO_REG != 0) && (wr_addr == ZA);
        iss_zero = (ZERO_REG != 0) && (iss_addr == ZA);
        // A writeback landing on the issue target this cycle resolves the
        // hazard, independent of whether read bypass is enabled.
        stall = iss_en && pending_q[iss_addr]
                && !(wr_en && (wr_addr == iss_addr)) && !iss_zero;

        pending_d = pending_q;
        if (wr_en && !wr_zero) begin
            pending_d[wr_addr] = 1'b0;
        end
        // Issue is applied after the clear so that it wins on a collision.
        if (iss_en && !stall && !iss_zero) begin
            pending_d[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              byp_hit;
        assign ra       = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (ra == ZA);
        assign byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == ra);
        assign rd_busy[i] = (zero_hit || byp_hit) ? 1'b0 : pending_q[ra];
    end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-read-port register file with
// same-cycle write bypass, optional hardwired zero register and an
// integrated pending-write scoreboard (rf_scoreboard).
//   clk, rst_n : clock, asynchronous active-low reset
//   rd_addr    : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    : packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy    : port i's register has an outstanding write
//   wr_en/wr_addr/wr_data : writeback
//   iss_en/iss_addr       : issue, marks destination pending
//   stall      : issue refused (WAW hazard)
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     stall
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_zero;

    always_comb begin
        wr_zero = (ZERO_REG != 0) && (wr_addr == ZA);
        mem_d   = mem_q;
        if (wr_en && !wr_zero) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_read
        logic [ADDR_W-1:0] ra;
        logic              zero_hit;
        logic              byp_hit;
        assign ra       = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
        assign zero_hit = (ZERO_REG != 0) && (ra == ZA);
        // Bypass is held off during reset so reads return 0 while rst_n is low.
        assign byp_hit  = (BYPASS != 0) && rst_n && wr_en && (wr_addr == ra);
        assign rd_data[port_lo(i, DATA_W) +: DATA_W] =
            zero_hit ? '0 : (byp_hit ? wr_data : mem_q[ra]);
    end

    rf_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .rd_busy (rd_busy),
        .stall   (stall)
    );

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;

    // a: NUM_RD=4, ZERO_REG=1, BYPASS=1
    logic [19:0]  rd_addr_a;
    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic         stall_a;
    // b: NUM_RD=2, ZERO_REG=1, BYPASS=0
    logic [9:0]   rd_addr_b;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic         stall_b;
    // c: ADDR_W=3, NUM_RD=2, ZERO_REG=0, BYPASS=1
    logic [5:0]   rd_addr_c;
    logic [63:0]  rd_data_c;
    logic [1:0]   rd_busy_c;
    logic         stall_c;

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .stall(stall_a));

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .stall(stall_b));

    register_file_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr[2:0]), .stall(stall_c));

    typedef struct {
        logic             we;
        logic [4:0]       wa;
        logic [31:0]      wd;
        logic             ie;
        logic [4:0]       ia;
        logic [3:0][4:0]  ra;
        logic [3:0][31:0] rd;
        logic [3:0]       busy;
        logic             stall;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];
    vec_t exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] r3,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [3:0] busy, input logic st);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
        v.rd[0] = d0; v.rd[1] = d1; v.rd[2] = d2; v.rd[3] = d3;
        v.busy = busy; v.stall = st;
        return v;
    endfunction

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
    endtask

    initial begin
        vec_t e;
        //             we wa  wd            ie ia   ra0 ra1 ra2 ra3  rd0            rd1     rd2     rd3   busy     stall
        vecs[0]  = mk(1, 20, 32'hF5,       0, 0,   20, 0,  0,  0,   32'hF5,        0,      0,      0,    4'b0000, 0);
        vecs[1]  = mk(0, 0,  0,            0, 0,   20, 0,  0,  0,   32'hF5,        0,      0,      0,    4'b0000, 0);
        vecs[2]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,   0,  20, 0,  0,   0,             32'hF5, 0,      0,    4'b0000, 0);
        vecs[3]  = mk(0, 0,  0,            0, 0,   0,  20, 0,  0,   0,             32'hF5, 0,      0,    4'b0000, 0);
        vecs[4]  = mk(0, 0,  0,            1, 17,  17, 0,  0,  0,   0,             0,      0,      0,    4'b0000, 0);
        vecs[5]  = mk(0, 0,  0,            1, 17,  17, 0,  0,  0,   0,             0,      0,      0,    4'b0001, 1);
        vecs[6]  = mk(1, 17, 32'h3,        1, 17,  17, 0,  0,  0,   32'h3,         0,      0,      0,    4'b0000, 0);
        vecs[7]  = mk(0, 0,  0,            0, 0,   17, 17, 0,  20,  32'h3,         32'h3,  0,      32'hF5, 4'b0011, 0);
        vecs[8]  = mk(1, 17, 32'h4,        0, 0,   17, 0,  0,  0,   32'h4,         0,      0,      0,    4'b0000, 0);
        vecs[9]  = mk(1, 5,  32'hA1,       0, 0,   5,  17, 0,  0,   32'hA1,        32'h4,  0,      0,    4'b0000, 0);
        vecs[10] = mk(1, 31, 32'hB2,       0, 0,   5,  31, 5,  0,   32'hA1,        32'hB2, 32'hA1, 0,    4'b0000, 0);
        vecs[11] = mk(0, 0,  0,            0, 0,   5,  31, 5,  17,  32'hA1,        32'hB2, 32'hA1, 32'h4, 4'b0000, 0);
        vecs[12] = mk(1, 9,  32'h77,       0, 0,   9,  0,  0,  0,   32'h77,        0,      0,      0,    4'b0000, 0);
        vecs[13] = mk(0, 0,  0,            1, 9,   9,  0,  0,  0,   32'h77,        0,      0,      0,    4'b0000, 0);
        vecs[14] = mk(0, 0,  0,            0, 0,   9,  9,  17, 0,   32'h77,        32'h77, 32'h4,  0,    4'b0011, 0);
        vecs[15] = mk(1, 12, 32'h55,       1, 9,   12, 9,  0,  0,   32'h55,        32'h77, 0,      0,    4'b0010, 1);

        // Reset held: reads of 20 and 0 give zero, nothing busy.
        rst_n = 1'b0;
        idle();
        rd_addr_a = {5'd0, 5'd0, 5'd0, 5'd20};
        rd_addr_a[9:5] = 5'd0;
        rd_addr_b = {5'd0, 5'd20};
        rd_addr_c = '0;
        repeat (2) @(negedge clk);
        #2;
        check("rst_rd0", rd_data_a[31:0], 32'h0);
        check("rst_rd1", rd_data_a[63:32], 32'h0);
        check("rst_busy", {28'h0, rd_busy_a}, 32'h0);
        check("rst_stall", {31'h0, stall_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence on the 4-port, bypassing instance.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            iss_en = vecs[i].ie; iss_addr = vecs[i].ia;
            rd_addr_a = vecs[i].ra;
            exp_q.push_back(vecs[i]);
            #2;
            e = exp_q.pop_front();
            for (int p = 0; p < 4; p++) begin
                check($sformatf("v%0d_rd%0d", i, p), rd_data_a[32*p +: 32], e.rd[p]);
                check($sformatf("v%0d_busy%0d", i, p), {31'h0, rd_busy_a[p]}, {31'h0, e.busy[p]});
            end
            check($sformatf("v%0d_stall", i), {31'h0, stall_a}, {31'h0, e.stall});
        end

        // Asynchronous reset with live state: no clock edge needed.
        @(negedge clk);
        idle();
        iss_en = 1'b1; iss_addr = 5'd9;
        rd_addr_a = {5'd9, 5'd31, 5'd20, 5'd5};
        #1;
        check("pre_arst_stall", {31'h0, stall_a}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("arst_rd%0d", p), rd_data_a[32*p +: 32], 32'h0);
        end
        check("arst_busy", {28'h0, rd_busy_a}, 32'h0);
        check("arst_stall", {31'h0, stall_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        iss_en = 1'b0;
        #2;
        check("post_arst_rd5", rd_data_a[31:0], 32'h0);
        check("post_arst_busy9", {31'h0, rd_busy_a[3]}, 32'h0);

        // No-bypass instance: old value in the write cycle, new value after.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hF5;
        rd_addr_b = {5'd20, 5'd20};
        #2;
        check("nobyp_old", rd_data_b[31:0], 32'h0);
        check("nobyp_busy", {30'h0, rd_busy_b}, 32'h0);
        @(negedge clk);
        idle();
        #2;
        check("nobyp_new0", rd_data_b[31:0], 32'hF5);
        check("nobyp_new1", rd_data_b[63:32], 32'hF5);

        // Writeback exemption on stall still applies without bypass.
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd17;
        rd_addr_b = {5'd0, 5'd17};
        #2;
        check("b_iss_stall", {31'h0, stall_b}, 32'h0);
        @(negedge clk);
        #2;
        check("b_waw_stall", {31'h0, stall_b}, 32'h1);
        check("b_waw_busy", {31'h0, rd_busy_b[0]}, 32'h1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'h3;
        #2;
        check("b_wb_stall", {31'h0, stall_b}, 32'h0);
        check("b_wb_busy", {31'h0, rd_busy_b[0]}, 32'h1);
        check("b_wb_rd", rd_data_b[31:0], 32'h0);
        @(negedge clk);
        idle();
        #2;
        check("b_after_rd", rd_data_b[31:0], 32'h3);
        check("b_after_busy", {31'h0, rd_busy_b[0]}, 32'h1);

        // Small-address instance without zero register: fill and read back.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(a) * 32'h11;
        end
        @(negedge clk);
        idle();
        for (int a = 0; a < 8; a++) begin
            rd_addr_c = {3'(7 - a), 3'(a)};
            #1;
            check($sformatf("c_rd0_a%0d", a), rd_data_c[31:0], 32'(a) * 32'h11);
            check($sformatf("c_rd1_a%0d", a), rd_data_c[63:32], 32'(7 - a) * 32'h11);
        end

        // Register 0 is ordinary storage here but hardwired on dut_a.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5A;
        iss_en = 1'b1; iss_addr = 5'd0;
        rd_addr_c = {3'd1, 3'd0};
        rd_addr_a = {5'd0, 5'd0, 5'd0, 5'd0};
        @(negedge clk);
        idle();
        #2;
        check("c_reg0_data", rd_data_c[31:0], 32'h5A);
        check("c_reg0_busy", {31'h0, rd_busy_c[0]}, 32'h1);
        check("a_reg0_data", rd_data_a[31:0], 32'h0);
        check("a_reg0_busy", {31'h0, rd_busy_a[0]}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
